// File: rtl/alu_mc.sv
// Multi-cycle ALU.
// Single-cycle ops produce a result one cycle after they are accepted.
// mult runs an n-step shift-add loop.
// The result is held in DONE until downstream takes it.
module alu_mc #(
  parameter int n = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   alucontrol,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [n-1:0] result,
  output logic [n-1:0] hi,
  output logic         zero
);

  localparam int CW = (n > 2) ? $clog2(n) : 1;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_MULT = 3'b011;
  localparam logic [2:0] OP_NOR  = 3'b100;
  localparam logic [2:0] OP_BNE  = 3'b101;
  localparam logic [2:0] OP_SUB  = 3'b110;
  localparam logic [2:0] OP_SLT  = 3'b111;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t         state_q, state_d;
  logic [n-1:0]   mcand_q, mcand_d;    // multiplicand
  logic [n-1:0]   mplr_q,  mplr_d;     // multiplier; fills with product low half
  logic [n-1:0]   acc_q,   acc_d;      // product high half accumulator
  logic [CW-1:0]  cnt_q,   cnt_d;
  logic [n-1:0]   result_q, result_d;
  logic [n-1:0]   hi_q,     hi_d;
  logic           zero_q,   zero_d;

  logic [n-1:0]   alu_r;
  logic           alu_z;
  logic [n-1:0]   diff;
  logic [n-1:0]   addend;
  logic [n:0]     step_sum;
  logic [n-1:0]   acc_step;
  logic [n-1:0]   mplr_step;

  // Single-cycle datapath, evaluated on the operands being accepted.
  always_comb begin
    diff  = a - b;
    alu_r = '0;
    case (alucontrol)
      OP_AND:  alu_r = a & b;
      OP_OR:   alu_r = a | b;
      OP_ADD:  alu_r = a + b;
      OP_SUB:  alu_r = diff;
      OP_SLT:  alu_r = {{(n-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_NOR:  alu_r = ~(a | b);
      OP_BNE:  alu_r = diff;
      default: alu_r = '0;
    endcase
    // For bne, zero acts as the branch-taken flag.
    alu_z = (alucontrol == OP_BNE) ? (a != b) : (alu_r == '0);
  end

  // One shift-add step: conditionally add, then shift {acc,mplr} right, keeping the carry.
  always_comb begin
    addend    = mplr_q[0] ? mcand_q : '0;
    step_sum  = {1'b0, acc_q} + {1'b0, addend};
    acc_step  = step_sum[n:1];
    mplr_step = {step_sum[0], mplr_q[n-1:1]};
  end

  // Next-state and datapath register updates.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplr_d   = mplr_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    hi_d     = hi_q;
    zero_d   = zero_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (alucontrol == OP_MULT) begin
            mcand_d = a;
            mplr_d  = b;
            acc_d   = '0;
            cnt_d   = CW'(n - 1);
            state_d = MUL;
          end else begin
            result_d = alu_r;
            hi_d     = '0;
            zero_d   = alu_z;
            state_d  = DONE;
          end
        end
      end
      MUL: begin
        acc_d  = acc_step;
        mplr_d = mplr_step;
        if (cnt_q == '0) begin
          result_d = mplr_step;
          hi_d     = acc_step;
          zero_d   = (mplr_step == '0);
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplr_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      hi_q     <= '0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplr_q   <= mplr_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      hi_q     <= hi_d;
      zero_q   <= zero_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign hi        = hi_q;
  assign zero      = zero_q;

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Multi-cycle ALU: the execute-side consumer of the 3-bit alucontrol code that the ALU decoder produces.
- Accepts one operation per valid/ready handshake and performs it; single-cycle ops finish in 1 cycle, mult runs an n-cycle shift-add loop.
- Holds the result until the downstream stage takes it.
- Sits between the decoder/register-read stage and writeback/branch logic in the 32-bit RISC datapath.

Parameters:
n, 32, operand and result width in bits (n >= 2)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operation request
in_ready  output  1  block can accept an operation (high only in IDLE)
alucontrol  input  3  operation code: 000 and, 001 or, 010 add, 110 sub, 111 slt, 100 nor, 011 mult, 101 bne
a  input  n  operand A
b  input  n  operand B
out_valid  output  1  result/hi/zero valid
out_ready  input  1  downstream accepts result
result  output  n  operation result (low half for mult)
hi  output  n  upper half of product for mult, 0 for all other ops
zero  output  1  result==0; for 101, 1 iff a!=b (branch-taken flag)

Behaviour:
- Reset (rst_n low, asynchronous, any state including mid-mult):
  - state=IDLE, in_ready=1, out_valid=0, result=0, hi=0, zero=0, counter and partial product cleared.
  - Deassertion is synchronous to clk.
- States:
  - IDLE: in_ready=1. On in_valid: latch alucontrol, a, b. Go to MUL if code is 011, else go to DONE with result computed from the latched operands.
  - MUL: in_ready=0, out_valid=0.
    - Counter loads n-1 on accept.
    - Each cycle: if multiplier LSB is 1, add multiplicand to the upper accumulator; then shift {acc,multiplier} right by 1, keeping the carry.
    - When counter==0, go to DONE.
    - Otherwise decrement the counter.
  - DONE: out_valid=1; result/hi/zero stable. If out_ready, go to IDLE next cycle, else hold.
- Latency (accept at edge t):
  - non-mult: out_valid high after edge t+1.
  - mult: out_valid high after edge t+n+1.
  - Peak throughput is one op per 2 cycles, because in_ready is low in DONE.
- Operands are captured at accept; later changes on a, b or alucontrol have no effect. in_valid while not in IDLE is ignored, and nothing is queued.
- Arithmetic:
  - add and sub wrap modulo 2^n; no overflow flag.
  - slt is a signed compare; result = {n-1 zeros, (a<b signed)}.
  - nor = ~(a|b).
  - 101 computes a-b in result; zero = (a!=b).
  - mult is unsigned; {hi,result} = a*b as a 2n-bit product.
- zero:
  - 101: as above.
  - All other ops including mult: zero = (result==0); hi is not considered.
- out_valid and in_ready are never high in the same cycle.

Test Plan:
1. Reset then add: a=5, b=7, code 010, in_valid 1 cycle -> result 12, hi 0, zero 0, out_valid exactly 1 cycle after accept; held for 3 cycles with out_ready=0, then cleared 1 cycle after out_ready=1.
2. Wrap and compare:
   - sub a=3, b=3 -> result 0, zero 1.
   - add 0xFFFFFFFF+1 -> result 0, zero 1.
   - slt a=0xFFFFFFFF, b=1 -> result 1.
   - bne a=4, b=9 -> result 0xFFFFFFFB, zero 1.
   - bne a=9, b=9 -> zero 0.
3. Mult latency: a=0xFFFFFFFF, b=0xFFFFFFFF, code 011 -> out_valid exactly 33 cycles after accept; hi 0xFFFFFFFE, result 0x00000001; in_ready low throughout. Also a=0, b=123 -> zero 1.
4. Operand isolation: change a, b, alucontrol and pulse in_valid during MUL -> ignored; result matches the captured operands; no second out_valid.
5. Reset mid-mult: assert rst_n low at cycle 10 of a mult, off-edge -> outputs clear immediately; after release the block is in IDLE with in_ready 1, and a following and 0xF0F0&0xFF00 -> 0xF000.
6. Logic ops and back-to-back: or, nor, and with out_ready tied high -> each result correct; in_ready/out_valid alternate, one op per 2 cycles.
